// File: rtl/irqctl_if.sv
// CPU-side register window bus of the IRQ controller.
interface irqctl_if;
  logic [2:0] addr;
  logic       cs;
  logic       rw;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (output addr, cs, rw, data_in, input  data_out, data_out_en);
  modport slave  (input  addr, cs, rw, data_in, output data_out, data_out_en);
endinterface

// File: rtl/irqctl.sv
// 6502 IRQB interrupt controller: per-source sync, level/edge latch, mask,
// fixed priority (bit 0 highest) and a small CPU register window.
module irqctl_src (
  input  logic clock,
  input  logic reset,
  input  logic src_n,
  input  logic mode,
  input  logic mode_clr,
  input  logic force_set,
  input  logic w1c_clr,
  output logic act,
  output logic pending
);
  logic s1, s2, prev, latch, fall;

  // Edge history runs in both modes so a switch to edge mode sees no stale edge.
  assign fall = prev & ~s2;
  assign act  = ~s2;
  assign pending = mode ? latch : act;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      latch <= 1'b0;
    end else begin
      s1   <= src_n;
      s2   <= s1;
      prev <= s2;
      if (!mode || mode_clr)    latch <= 1'b0;
      else if (fall || force_set) latch <= 1'b1;
      else if (w1c_clr)         latch <= 1'b0;
    end
  end
endmodule

module irqctl #(
  parameter int          NSRC         = 8,
  parameter logic [7:0]  ENABLE_RESET = 8'h00
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src_n,
  irqctl_if.slave         bus,
  output logic            irq_n,
  output logic [7:0]      pending_vec
);
  localparam logic [8:0] IMPL9 = (9'd1 << NSRC) - 9'd1;
  localparam logic [7:0] IMPL  = IMPL9[7:0];

  logic [7:0] enable, mode, act, pend, vector;
  logic       wr, wr_pend, wr_en, wr_mode, wr_force;

  assign wr       = ~bus.cs & ~bus.rw;
  assign wr_pend  = wr && (bus.addr == 3'd1);
  assign wr_en    = wr && (bus.addr == 3'd2);
  assign wr_mode  = wr && (bus.addr == 3'd3);
  assign wr_force = wr && (bus.addr == 3'd5);

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_src
      if (i < NSRC) begin : g_impl
        irqctl_src u_src (
          .clock     (clock),
          .reset     (reset),
          .src_n     (src_n[i]),
          .mode      (mode[i]),
          .mode_clr  (wr_mode & ~bus.data_in[i]),
          .force_set (wr_force & bus.data_in[i]),
          .w1c_clr   (wr_pend & bus.data_in[i]),
          .act       (act[i]),
          .pending   (pend[i])
        );
      end else begin : g_tie
        assign act[i]  = 1'b0;
        assign pend[i] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable <= ENABLE_RESET & IMPL;
      mode   <= 8'h00;
    end else begin
      if (wr_en)   enable <= bus.data_in & IMPL;
      if (wr_mode) mode   <= bus.data_in & IMPL;
    end
  end

  assign pending_vec = pend & enable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_n <= 1'b1;
    else       irq_n <= ~|pending_vec;
  end

  // Scan from the top so the lowest set index wins.
  always_comb begin
    vector = 8'h80;
    for (int k = 7; k >= 0; k--)
      if (pending_vec[k]) vector = {5'd0, k[2:0]};
  end

  always_comb begin
    bus.data_out = 8'h00;
    case (bus.addr)
      3'd0: bus.data_out = act;
      3'd1: bus.data_out = pend;
      3'd2: bus.data_out = enable;
      3'd3: bus.data_out = mode;
      3'd4: bus.data_out = vector;
      default: bus.data_out = 8'h00;
    endcase
  end

  assign bus.data_out_en = ~bus.cs & bus.rw;
endmodule

// File: tb/tb_irqctl.sv
// Directed bench for irqctl: register-level vector table plus latency,
// edge-latch, set/clear race and async reset sequences.
module tb_irqctl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] src_n = 8'hFF;
  logic       irq_n;
  logic [7:0] pending_vec;
  int n_chk = 0;
  int n_err = 0;

  irqctl_if bus ();

  irqctl #(.NSRC(8), .ENABLE_RESET(8'h00)) dut (
    .clock       (clock),
    .reset       (reset),
    .src_n       (src_n),
    .bus         (bus.slave),
    .irq_n       (irq_n),
    .pending_vec (pending_vec)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [7:0] src;
    logic [7:0] en;
    logic [2:0] a;
    logic [7:0] exp_d;
    logic       exp_irq;
  } vec_t;
  vec_t tbl [14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.addr = a; bus.data_in = d; bus.cs = 1'b0; bus.rw = 1'b0;
    tick();
    bus.cs = 1'b1; bus.rw = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    bus.addr = a; bus.cs = 1'b0; bus.rw = 1'b1;
    #1;
    chk(name, bus.data_out, exp);
    bus.cs = 1'b1;
    #1;
  endtask

  initial begin
    bus.addr = 3'd0; bus.cs = 1'b1; bus.rw = 1'b1; bus.data_in = 8'h00;

    tbl[0]  = '{8'hFF, 8'h00, 3'd0, 8'h00, 1'b1};
    tbl[1]  = '{8'hFF, 8'h00, 3'd4, 8'h80, 1'b1};
    tbl[2]  = '{8'hFB, 8'h05, 3'd4, 8'h02, 1'b0};
    tbl[3]  = '{8'hBD, 8'hFF, 3'd4, 8'h01, 1'b0};
    tbl[4]  = '{8'hBD, 8'h40, 3'd4, 8'h06, 1'b0};
    tbl[5]  = '{8'hBD, 8'h00, 3'd4, 8'h80, 1'b1};
    tbl[6]  = '{8'hBD, 8'h00, 3'd0, 8'h42, 1'b1};
    tbl[7]  = '{8'hBD, 8'hFF, 3'd1, 8'h42, 1'b0};
    tbl[8]  = '{8'h7F, 8'h80, 3'd4, 8'h07, 1'b0};
    tbl[9]  = '{8'h00, 8'hFF, 3'd4, 8'h00, 1'b0};
    tbl[10] = '{8'hFF, 8'hFF, 3'd4, 8'h80, 1'b1};
    tbl[11] = '{8'h00, 8'hFF, 3'd6, 8'h00, 1'b0};
    tbl[12] = '{8'h00, 8'hFF, 3'd5, 8'h00, 1'b0};
    tbl[13] = '{8'hFF, 8'hA5, 3'd2, 8'hA5, 1'b1};

    // Reset state
    #15 reset = 1'b0;
    tick();
    chk("rst_irq", {7'd0, irq_n}, 8'h01);
    chk("rst_oe", {7'd0, bus.data_out_en}, 8'h00);
    rd_chk("rst_status", 3'd0, 8'h00);
    rd_chk("rst_vector", 3'd4, 8'h80);
    rd_chk("rst_enable", 3'd2, 8'h00);

    // Level-mode register table
    for (int i = 0; i < 14; i++) begin
      src_n = tbl[i].src;
      wr(3'd3, 8'h00);
      wr(3'd2, tbl[i].en);
      repeat (4) tick();
      rd_chk($sformatf("tbl%0d_data", i), tbl[i].a, tbl[i].exp_d);
      chk($sformatf("tbl%0d_irq", i), {7'd0, irq_n}, {7'd0, tbl[i].exp_irq});
    end

    // Level latency: low before edge k -> irq_n low after k+2
    src_n = 8'hFF;
    wr(3'd3, 8'h00);
    wr(3'd2, 8'h05);
    repeat (4) tick();
    src_n[2] = 1'b0;
    tick(); chk("lvl_k",  {7'd0, irq_n}, 8'h01);
    tick(); chk("lvl_k1", {7'd0, irq_n}, 8'h01);
    tick(); chk("lvl_k2", {7'd0, irq_n}, 8'h00);
    rd_chk("lvl_vector", 3'd4, 8'h02);
    src_n[2] = 1'b1;
    tick(); tick();
    chk("lvl_rel2", {7'd0, irq_n}, 8'h00);
    tick();
    chk("lvl_rel3", {7'd0, irq_n}, 8'h01);

    // Edge mode: 3-clock pulse latches, W1C releases next clock
    wr(3'd3, 8'h01);
    wr(3'd2, 8'h01);
    repeat (4) tick();
    src_n[0] = 1'b0;
    tick(); chk("edge_k",  {7'd0, irq_n}, 8'h01);
    tick(); chk("edge_k1", {7'd0, irq_n}, 8'h01);
    tick(); chk("edge_k2", {7'd0, irq_n}, 8'h01);
    src_n[0] = 1'b1;
    tick(); chk("edge_k3", {7'd0, irq_n}, 8'h00);
    repeat (5) tick();
    chk("edge_hold", {7'd0, irq_n}, 8'h00);
    chk("edge_pvec", pending_vec, 8'h01);
    rd_chk("edge_pend", 3'd1, 8'h01);
    wr(3'd1, 8'h01);
    chk("w1c_same", {7'd0, irq_n}, 8'h00);
    rd_chk("w1c_pend", 3'd1, 8'h00);
    tick();
    chk("w1c_next", {7'd0, irq_n}, 8'h01);

    // Writing MODE bit to 0 clears its latch
    wr(3'd5, 8'h01);
    rd_chk("force_pend", 3'd1, 8'h01);
    wr(3'd3, 8'h00);
    rd_chk("modeclr_pend", 3'd1, 8'h00);

    // Set beats clear: W1C on the same edge as a new fall
    wr(3'd3, 8'h08);
    wr(3'd2, 8'h08);
    wr(3'd5, 8'h08);
    rd_chk("race_pre", 3'd1, 8'h08);
    src_n[3] = 1'b0;
    tick(); tick();
    wr(3'd1, 8'h08);
    rd_chk("race_set", 3'd1, 8'h08);
    wr(3'd1, 8'h08);
    rd_chk("race_w1c", 3'd1, 8'h00);
    src_n[3] = 1'b1;
    wr(3'd3, 8'h00);
    repeat (4) tick();
    wr(3'd5, 8'h08);
    rd_chk("force_lvl", 3'd1, 8'h00);
    rd_chk("force_rd", 3'd5, 8'h00);

    // Async reset with pending edge latches
    wr(3'd3, 8'h0F);
    wr(3'd2, 8'h0F);
    wr(3'd5, 8'h0F);
    tick();
    chk("pre_rst_irq", {7'd0, irq_n}, 8'h00);
    rd_chk("pre_rst_pend", 3'd1, 8'h0F);
    #2 reset = 1'b1;
    #1 chk("async_rst_irq", {7'd0, irq_n}, 8'h01);
    tick();
    #2 reset = 1'b0;
    repeat (3) tick();
    rd_chk("post_rst_pend", 3'd1, 8'h00);
    rd_chk("post_rst_mode", 3'd3, 8'h00);
    chk("post_rst_irq", {7'd0, irq_n}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/irqctl.md
Name: irqctl

Overview:
- Interrupt controller that sits directly upstream of the 6502 IRQB pin inside BIFRÖST.
- Replaces the plain AND of the active-low peripheral IRQ lines: VIA1, VIA2, UART, and the UART channel TX/RX lines.
- Each source is synchronised, latched per source as level or falling-edge, masked, and prioritised.
- Presents a small register window behind bifrost_cs, so the CPU can identify and acknowledge the source.

Parameters:
- NSRC, 8, number of implemented sources (1..8). Unimplemented bits read 0 and never interrupt.
- ENABLE_RESET, 8'h00, reset value of the ENABLE register.

Ports:
- clock  input  1  system bus clock (6502 phi2, one bus cycle per rising edge)
- reset  input  1  asynchronous, active-high reset
- src_n  input  NSRC  raw active-low interrupt requests, asynchronous to clock
- addr  input  3  register select (bus addr[2:0])
- cs  input  1  active-low chip select for the irqctl window
- rw  input  1  6502 R/W: 1 = read, 0 = write
- data_in  input  8  write data
- data_out  output  8  read data, combinational from addr
- data_out_en  output  1  high when ~cs & rw; top level muxes data_out onto the data bus
- irq_n  output  1  registered active-low IRQ to the CPU
- pending_vec  output  8  (pending & enable), for the LED debug mux

Behaviour:
- Reset (async, active-high):
  - sync flops and edge-history flops = 1 (inactive).
  - LATCH = 0, ENABLE = ENABLE_RESET, MODE = 0.
  - irq_n = 1.
  - Reset mid-operation drops irq_n to 1 immediately and discards all latched edges.
- Synchroniser: two flops per source, s1 then s2.
  - act[i] = ~s2[i].
  - prev[i] = s2[i], delayed one clock.
- Edge detect: fall[i] = prev[i] & ~s2[i].
  - Evaluated in every mode, so switching to edge mode never fabricates an edge.
- PENDING[i]:
  - Level mode (MODE[i] = 0): act[i], live, not latched.
  - Edge mode (MODE[i] = 1): LATCH[i].
- LATCH[i] next value:
  - 0 if MODE[i] = 0.
  - Otherwise, set if fall[i] or a FORCE write sets bit i.
  - Otherwise, cleared if a W1C PENDING write has bit i set.
  - Set beats clear in the same cycle.
- irq_n register <= ~|(PENDING & ENABLE), updated every clock.
- Latency, input low before rising edge k:
  - s1 at k, s2 at k+1.
  - Level mode: irq_n low after edge k+2.
  - Edge mode: LATCH set at k+2, irq_n low after k+3.
- Masking:
  - Clearing ENABLE[i] does not clear LATCH[i]; re-enabling re-asserts irq_n one clock later.
  - irq_n deasserts one clock after the last enabled pending bit clears or is masked.
- Register map (write on rising clock when ~cs & ~rw; one write per bus cycle):
  - 0 STATUS, R: act[7:0]. Writes ignored.
  - 1 PENDING, R: PENDING. W: write-1-to-clear LATCH; no effect on level-mode bits.
  - 2 ENABLE, R/W.
  - 3 MODE, R/W. A bit written to 0 clears its LATCH in the same edge.
  - 4 VECTOR, R:
    - bits[2:0] = index of the lowest-numbered set bit of (PENDING & ENABLE); bit 0 has highest priority.
    - bit7 = 1 when none is set, and then bits[2:0] = 0.
    - Reads have no side effects.
  - 5 FORCE, W: set LATCH for bits with MODE = 1. Reads return 0.
  - 6, 7: read 0, writes ignored.
- Register reads are combinational: ENABLE/MODE/LATCH values, the live act synchroniser outputs, and VECTOR/PENDING derived from them. A write takes effect for reads on the following cycle.
- Bits >= NSRC are tied 0 in every register.

Test Plan:
- Reset, all src_n = 1, ENABLE_RESET = 0 → irq_n = 1, STATUS = 00, VECTOR = 80, data_out_en = 0 while cs = 1.
- Level mode: write ENABLE = 05, drive src_n[2] = 0 before edge k → irq_n = 0 after edge k+2, VECTOR = 02. Release src_n[2] → irq_n = 1 three edges later with no software action.
- Edge mode: MODE = 01, ENABLE = 01, pulse src_n[0] low for 3 clocks → PENDING = 01 and irq_n low and held. Write PENDING = 01 → irq_n = 1 next clock.
- Priority/mask: level sources 1 and 6 both active, ENABLE = FF → VECTOR = 01. Write ENABLE = 40 → VECTOR = 06. Write ENABLE = 00 → irq_n = 1 and VECTOR = 80, while STATUS still = 42.
- Set-vs-clear race: edge mode on bit 3, W1C PENDING = 08 on the same edge a new falling edge reaches fall[3] → LATCH[3] remains 1. FORCE = 08 with MODE[3] = 0 → no effect.
- Async reset asserted mid-pending (irq_n = 0, LATCH = 0F) → irq_n = 1 with no clock edge. After release, PENDING = 00 for edge-mode bits.
